// File: rtl/hilo_muldiv_unit.sv
// Iterative 1-bit/cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Optional MADD/MSUB accumulate path is compiled in with `define HILO_MADD_EN.
//
// state   | meaning
// IDLE    | waiting for Start; Hi/Lo stable
// PREP    | take operand magnitudes, record signs, load iteration count
// RUN     | one shift-add (mul) or shift-subtract (div) step per cycle
// FIX     | sign-correct the raw result, write Hi/Lo, pulse Done
// ACC_FIX | (HILO_MADD_EN only) add/subtract the product into {Hi,Lo}
module hilo_muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              ReadHiLo,
   input  logic              Flush,
`ifdef HILO_MADD_EN
   input  logic              Acc,
   input  logic              Sub,
`endif
   output logic              Stall,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      RUN,
      FIX
`ifdef HILO_MADD_EN
      , ACC_FIX
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_W-1:0]     opa_q, opa_d;
   logic [DATA_W-1:0]     opb_q, opb_d;
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  neg_res_q, neg_res_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [DATA_W-1:0]     hi_q, hi_d;
   logic [DATA_W-1:0]     lo_q, lo_d;
   logic                  done_q, done_d;
`ifdef HILO_MADD_EN
   logic                  acc_en_q, acc_en_d;
   logic                  sub_q, sub_d;
`endif

   logic                  a_neg, b_neg;
   logic [DATA_W-1:0]     abs_a, abs_b;
   logic [DATA_W:0]       mul_sum;
   logic [DATA_W:0]       div_shift, div_diff;
   logic                  div_ok;
   logic [2*DATA_W-1:0]   prod_fix;
   logic [DATA_W-1:0]     rem_fix, quo_fix;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
`ifdef HILO_MADD_EN
      acc_en_d  = acc_en_q;
      sub_d     = sub_q;
`endif

      a_neg     = op_q[0] & opa_q[DATA_W-1];
      b_neg     = op_q[0] & opb_q[DATA_W-1];
      abs_a     = a_neg ? (~opa_q + 1'b1) : opa_q;
      abs_b     = b_neg ? (~opb_q + 1'b1) : opb_q;

      // Multiply: upper half accumulates the multiplicand, lower half shifts out multiplier bits.
      mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
      div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ok    = ~div_diff[DATA_W];

      prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      rem_fix   = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
      quo_fix   = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];

      case (state_q)
         IDLE: begin
            if (Start && !Flush) begin
               op_d    = Op;
               opa_d   = A;
               opb_d   = B;
`ifdef HILO_MADD_EN
               acc_en_d = Acc & ~Op[1];
               sub_d    = Sub;
`endif
               state_d = PREP;
            end
         end
         PREP: begin
            opa_d     = abs_a;
            opb_d     = abs_b;
            acc_d     = {{DATA_W{1'b0}}, abs_a};
            cnt_d     = CNT_LAST;
            // Divide by zero keeps the raw all-ones quotient, so no quotient negation.
            neg_res_d = (a_neg ^ b_neg) & ~(op_q[1] && (opb_q == '0));
            neg_rem_d = a_neg;
            state_d   = RUN;
         end
         RUN: begin
            if (op_q[1])
               acc_d = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                        acc_q[DATA_W-2:0], div_ok};
            else
               acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            if (cnt_q == '0)
               state_d = FIX;
            else
               cnt_d = cnt_q - 1'b1;
         end
         FIX: begin
            state_d = IDLE;
`ifdef HILO_MADD_EN
            if (acc_en_q) begin
               acc_d   = prod_fix;
               state_d = ACC_FIX;
            end else
`endif
            begin
               if (op_q[1]) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*DATA_W-1:DATA_W];
                  lo_d = prod_fix[DATA_W-1:0];
               end
               done_d = 1'b1;
            end
         end
`ifdef HILO_MADD_EN
         ACC_FIX: begin
            {hi_d, lo_d} = sub_q ? ({hi_q, lo_q} - acc_q) : ({hi_q, lo_q} + acc_q);
            done_d       = 1'b1;
            state_d      = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      if (Flush && (state_q != IDLE)) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
`ifdef HILO_MADD_EN
         acc_en_q  <= 1'b0;
         sub_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
`ifdef HILO_MADD_EN
         acc_en_q  <= acc_en_d;
         sub_q     <= sub_d;
`endif
      end
   end

   assign Busy  = (state_q != IDLE);
   assign Stall = Busy & (Start | ReadHiLo);
   assign Done  = done_q;
   assign Hi    = hi_q;
   assign Lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit: vector table plus stall, flush and reset sequences.
module tb_hilo_muldiv_unit;

   localparam int W = 32;
   localparam int LAT = W + 2;

   logic         Clk = 1'b0;
   logic         Rst_n;
   logic         Start, ReadHiLo, Flush;
   logic [1:0]   Op;
   logic [W-1:0] A, B;
   logic         Stall, Busy, Done;
   logic [W-1:0] Hi, Lo;

   int n_pass = 0;
   int n_total = 0;

   hilo_muldiv_unit #(.DATA_W(W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
      .ReadHiLo(ReadHiLo), .Flush(Flush), .Stall(Stall), .Busy(Busy),
      .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      string        name;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string nm);
      int cyc;
      bit seen;
      Op = op; A = a; B = b; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < LAT + 10) begin
         @(posedge Clk); #1;
         cyc++;
         if (Done) seen = 1'b1;
      end
      chk({nm, " latency"}, 64'(cyc), 64'(LAT));
      chk({nm, " hi"}, 64'(Hi), 64'(exp_hi));
      chk({nm, " lo"}, 64'(Lo), 64'(exp_lo));
      @(posedge Clk); #1;
      chk({nm, " done_once"}, 64'(Done), 64'd0);
   endtask

   initial begin
      int cyc, bad, ndone;
      bit seen;

      vecs[0]  = '{2'b01, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
      vecs[1]  = '{2'b10, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7"};
      vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
      vecs[3]  = '{2'b10, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
      vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div_ovf"};
      vecs[5]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
      vecs[6]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7_neg2"};
      vecs[7]  = '{2'b11, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_neg_by0"};
      vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,       "mult_minxmin"};
      vecs[9]  = '{2'b00, 32'h1234_5678, 32'h10,       32'd1,         32'h2345_6780, "multu_shift"};
      vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         "mult_neg1sq"};

      Rst_n = 1'b0; Start = 1'b0; ReadHiLo = 1'b0; Flush = 1'b0;
      Op = 2'b00; A = '0; B = '0;
      #12;
      chk("rst hi", 64'(Hi), 64'd0);
      chk("rst lo", 64'(Lo), 64'd0);
      chk("rst busy", 64'(Busy), 64'd0);
      chk("rst done", 64'(Done), 64'd0);
      chk("rst stall", 64'(Stall), 64'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk); #1;

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

      // Stall held by a HI/LO read presented 5 cycles into MULTU max*max
      Op = 2'b00; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      cyc = 0; bad = 0; seen = 1'b0;
      while (!seen && cyc < LAT + 10) begin
         @(posedge Clk); #1;
         cyc++;
         if (Done) seen = 1'b1;
         else if (Stall !== (cyc > 5)) bad++;
         if (cyc == 5) ReadHiLo = 1'b1;
      end
      chk("stall latency", 64'(cyc), 64'(LAT));
      chk("stall held", 64'(bad), 64'd0);
      chk("stall done_cycle", 64'(Stall), 64'd0);
      chk("stall read hi", 64'(Hi), 64'hFFFF_FFFE);
      chk("stall read lo", 64'(Lo), 64'h0000_0001);
      ReadHiLo = 1'b0;
      @(posedge Clk); #1;

      // Flush mid-divide keeps previous Hi/Lo
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "pre_flush");
      Op = 2'b10; A = 32'd1000; B = 32'd3; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (9) begin @(posedge Clk); #1; end
      Flush = 1'b1;
      @(posedge Clk); #1;
      Flush = 1'b0;
      chk("flush busy", 64'(Busy), 64'd0);
      chk("flush done", 64'(Done), 64'd0);
      chk("flush hi", 64'(Hi), 64'd2);
      chk("flush lo", 64'(Lo), 64'd14);
      ndone = 0;
      repeat (LAT + 5) begin @(posedge Clk); #1; if (Done) ndone++; end
      chk("flush no_done", 64'(ndone), 64'd0);
      chk("flush hi_after", 64'(Hi), 64'd2);

      // Start dropped when it coincides with Flush in IDLE
      Op = 2'b00; A = 32'd3; B = 32'd3; Start = 1'b1; Flush = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0; Flush = 1'b0;
      chk("start_flush busy", 64'(Busy), 64'd0);

      // Asynchronous reset in the middle of RUN
      Op = 2'b10; A = 32'd5000; B = 32'd9; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (15) begin @(posedge Clk); #1; end
      #2 Rst_n = 1'b0;
      #1;
      chk("arst hi", 64'(Hi), 64'd0);
      chk("arst lo", 64'(Lo), 64'd0);
      chk("arst busy", 64'(Busy), 64'd0);
      chk("arst done", 64'(Done), 64'd0);
      #3 Rst_n = 1'b1;
      @(posedge Clk); #1;
      run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
